// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package ssd_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } ssd_state_e;

  localparam int SSD_DIGITS     = 4;
  localparam int SSD_WIDTH      = 16;
  localparam int HOLD_CYCLES_1S = 100_000_000;

endpackage

// File: rtl/ssd_display_arbiter_rr_picker.sv
// Combinational round-robin picker; search starts one past last,
// so the previous owner is considered last.
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int IW = $clog2(NREQ);

  int idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!any && req[idx[IW-1:0]]) begin
        any    = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Round-robin time-sharing of the 4-digit display between requesters,
// with a guaranteed minimum hold per grant.
module ssd_display_arbiter
  import ssd_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = HOLD_CYCLES_1S
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic [NREQ-1:0]           req,
  input  logic [SSD_WIDTH*NREQ-1:0] data,
  output logic [NREQ-1:0]           grant,
  output logic [SSD_WIDTH-1:0]      number,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic                      slot_done
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("ssd_display_arbiter: NREQ must be 2..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("ssd_display_arbiter: HOLD_CYCLES must be >= 1");
  end

  ssd_state_e           state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [SSD_WIDTH-1:0] number_q, number_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 slot_done_q, slot_done_d;

  logic                 any;
  logic [IW-1:0]        win;
  logic [SSD_WIDTH-1:0] words [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_word
    assign words[i] = data[SSD_WIDTH*i +: SSD_WIDTH];
  end

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req    (req),
    .last   (owner_q),
    .any    (any),
    .winner (win)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    number_d    = number_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    slot_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (any) begin
          state_d  = ST_HOLD;
          grant_d  = NREQ'(1) << win;
          owner_d  = win;
          number_d = words[win];
          cnt_d    = CW'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          slot_done_d = 1'b1;
          if (any) begin
            grant_d  = NREQ'(1) << win;
            owner_d  = win;
            number_d = words[win];
            cnt_d    = CW'(HOLD_CYCLES - 1);
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          // a dropped request freezes the value but not the hold
          if (req[owner_q]) number_d = words[owner_q];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      number_q    <= '0;
      owner_q     <= IW'(NREQ - 1);
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      slot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      number_q    <= number_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      slot_done_q <= slot_done_d;
    end
  end

  assign grant     = grant_q;
  assign number    = number_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign slot_done = slot_done_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Directed bench for ssd_display_arbiter with NREQ=4, HOLD_CYCLES=8.
module tb_ssd_display_arbiter;

  logic        clk;
  logic        clr_n;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  grant;
  logic [15:0] number;
  logic [1:0]  owner;
  logic        busy;
  logic        slot_done;

  int n_chk;
  int n_pass;

  ssd_display_arbiter #(
    .NREQ        (4),
    .HOLD_CYCLES (8)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .number    (number),
    .owner     (owner),
    .busy      (busy),
    .slot_done (slot_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic put(input int i, input logic [15:0] v);
    data[16*i +: 16] = v;
  endtask

  task automatic do_reset();
    step();
    clr_n = 1'b0;
    req   = '0;
    step();
    clr_n = 1'b1;
  endtask

  logic [3:0]  exp_g [5];
  logic [15:0] exp_n [5];
  int          bad;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    clr_n  = 1'b0;
    req    = '0;
    data   = '0;
    step();
    clr_n = 1'b1;

    // 1: idle after reset
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_number", 32'(number), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h3);
    check("rst_slot", 32'(slot_done), 32'h0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (grant != 0 || number != 0 || busy != 0) bad++;
    end
    check("idle_1000", 32'(bad), 32'h0);

    // 2: single requester, back-to-back re-grant
    req = 4'b0100;
    put(2, 16'hBEEF);
    step();
    check("t2_grant", 32'(grant), 32'h4);
    check("t2_number", 32'(number), 32'hBEEF);
    check("t2_busy", 32'(busy), 32'h1);
    check("t2_owner", 32'(owner), 32'h2);
    repeat (7) step();
    check("t2_slot_pre", 32'(slot_done), 32'h0);
    check("t2_grant_last", 32'(grant), 32'h4);
    step();
    check("t2_slot", 32'(slot_done), 32'h1);
    check("t2_regrant", 32'(grant), 32'h4);
    check("t2_busy_regrant", 32'(busy), 32'h1);
    step();
    check("t2_slot_post", 32'(slot_done), 32'h0);

    // 3: all four request from reset
    do_reset();
    req  = 4'b1111;
    data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_n = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t3_grant_first%0d", k), 32'(grant), 32'(exp_g[k]));
      check($sformatf("t3_number%0d", k), 32'(number), 32'(exp_n[k]));
      check($sformatf("t3_slot%0d", k), 32'(slot_done),
            (k == 0) ? 32'h0 : 32'h1);
      repeat (7) step();
      check($sformatf("t3_grant_last%0d", k), 32'(grant), 32'(exp_g[k]));
    end

    // 4: owner drops request, value freezes, hold completes
    do_reset();
    req = 4'b0010;
    put(1, 16'h5A5A);
    step();
    check("t4_grant", 32'(grant), 32'h2);
    check("t4_number", 32'(number), 32'h5A5A);
    repeat (2) step();
    req = 4'b0000;
    put(1, 16'h1234);
    step();
    check("t4_frozen", 32'(number), 32'h5A5A);
    repeat (4) step();
    check("t4_grant_last", 32'(grant), 32'h2);
    check("t4_frozen_last", 32'(number), 32'h5A5A);
    step();
    check("t4_idle_grant", 32'(grant), 32'h0);
    check("t4_idle_busy", 32'(busy), 32'h0);
    check("t4_slot", 32'(slot_done), 32'h1);
    check("t4_keep_number", 32'(number), 32'h5A5A);

    // 5: live update while owner keeps requesting
    req = 4'b1000;
    put(3, 16'h0001);
    step();
    check("t5_owner", 32'(owner), 32'h3);
    check("t5_number1", 32'(number), 32'h0001);
    repeat (3) step();
    check("t5_number_pre", 32'(number), 32'h0001);
    put(3, 16'h0002);
    step();
    check("t5_number2", 32'(number), 32'h0002);

    // 6: asynchronous reset mid-hold
    do_reset();
    req = 4'b0100;
    put(2, 16'hCCCC);
    step();
    check("t6_grant", 32'(grant), 32'h4);
    repeat (4) step();
    #2 clr_n = 1'b0;
    #1;
    check("t6_async_grant", 32'(grant), 32'h0);
    check("t6_async_number", 32'(number), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    check("t6_async_owner", 32'(owner), 32'h3);
    check("t6_async_slot", 32'(slot_done), 32'h0);
    step();
    clr_n = 1'b1;
    req   = 4'b1001;
    put(0, 16'hAAAA);
    put(3, 16'hBBBB);
    step();
    check("t6_first_grant", 32'(grant), 32'h1);
    check("t6_first_number", 32'(number), 32'hAAAA);
    check("t6_first_owner", 32'(owner), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
